// File: rtl/curtain_motion_ctrl.sv
// curtain_motion_ctrl: light-driven open/close decision with hysteresis, rate-limited half-step pulses, end-stop-safe position tracking
module curtain_motion_ctrl #(
    parameter int STEP_DIV   = 50000,
    parameter int POS_MAX    = 4096,
    parameter int SETTLE_CYC = 1000,
    localparam int PW = $clog2(POS_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          light_valid,
    input  logic [7:0]    light_level,
    input  logic [7:0]    thr_open,
    input  logic [7:0]    thr_close,
    output logic          step,
    output logic          dir,
    output logic          busy,
    output logic [PW-1:0] pos,
    output logic          at_open,
    output logic          at_closed
);
    localparam int RW = $clog2(STEP_DIV);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam logic [RW-1:0] RATE_LD   = RW'(STEP_DIV - 1);
    localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYC - 1);
    localparam logic [PW-1:0] POS_END   = PW'(POS_MAX);

    typedef enum logic [1:0] {IDLE, MOVE, SETTLE} state_t;

    state_t        r_state, w_state_nx;
    logic          r_dir, w_dir_nx;
    logic          r_step, w_step_nx;
    logic [PW-1:0] r_pos, w_pos_nx;
    logic [RW-1:0] r_rate, w_rate_nx;
    logic [SW-1:0] r_settle, w_settle_nx;
    logic          w_cfg_ok, w_req_close, w_req_open;
    logic [PW-1:0] w_target;

    // Inverted thresholds would make both requests possible, so such configs drop every sample
    assign w_cfg_ok    = thr_open < thr_close;
    assign w_req_close = light_valid && w_cfg_ok && (light_level > thr_close);
    assign w_req_open  = light_valid && w_cfg_ok && (light_level < thr_open);
    assign w_target    = r_dir ? POS_END : '0;

    // State and datapath registers; reset parks the model at the open end stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_dir    <= 1'b0;
            r_step   <= 1'b0;
            r_pos    <= '0;
            r_rate   <= '0;
            r_settle <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_dir    <= w_dir_nx;
            r_step   <= w_step_nx;
            r_pos    <= w_pos_nx;
            r_rate   <= w_rate_nx;
            r_settle <= w_settle_nx;
        end
    end

    // Next-state logic; a move ends one edge after pos reaches its target, so no step can pass an end stop
    always_comb begin
        w_state_nx  = r_state;
        w_dir_nx    = r_dir;
        w_step_nx   = 1'b0;
        w_pos_nx    = r_pos;
        w_rate_nx   = r_rate;
        w_settle_nx = r_settle;
        case (r_state)
            IDLE: begin
                if (w_req_close && r_pos != POS_END) begin
                    w_state_nx = MOVE;
                    w_dir_nx   = 1'b1;
                    w_rate_nx  = RATE_LD;
                end else if (w_req_open && r_pos != '0) begin
                    w_state_nx = MOVE;
                    w_dir_nx   = 1'b0;
                    w_rate_nx  = RATE_LD;
                end
            end
            MOVE: begin
                if ((r_dir ? w_req_open : w_req_close) || r_pos == w_target) begin
                    w_state_nx  = SETTLE;
                    w_settle_nx = SETTLE_LD;
                end else if (r_rate == '0) begin
                    w_step_nx = 1'b1;
                    w_pos_nx  = r_dir ? r_pos + PW'(1) : r_pos - PW'(1);
                    w_rate_nx = RATE_LD;
                end else begin
                    w_rate_nx = r_rate - RW'(1);
                end
            end
            SETTLE: begin
                if (r_settle == '0) w_state_nx = IDLE;
                else w_settle_nx = r_settle - SW'(1);
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign step      = r_step;
    assign dir       = r_dir;
    assign pos       = r_pos;
    assign busy      = r_state != IDLE;
    assign at_open   = r_pos == '0;
    assign at_closed = r_pos == POS_END;
endmodule

// File: tb/tb_curtain_motion_ctrl.sv
// tb_curtain_motion_ctrl: directed scoreboard bench for the curtain motion controller
module tb_curtain_motion_ctrl;
    localparam int STEP_DIV = 4;
    localparam int POS_MAX = 10;
    localparam int SETTLE_CYC = 3;
    localparam int PW = $clog2(POS_MAX + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          light_valid = 1'b0;
    logic [7:0]    light_level = 8'd0;
    logic [7:0]    thr_open = 8'd50;
    logic [7:0]    thr_close = 8'd150;
    logic          step, dir, busy, at_open, at_closed;
    logic [PW-1:0] pos;

    typedef struct {int pos; logic dir;} exp_t;
    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;
    int steps;

    curtain_motion_ctrl #(.STEP_DIV(STEP_DIV), .POS_MAX(POS_MAX), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .light_valid(light_valid), .light_level(light_level),
        .thr_open(thr_open), .thr_close(thr_close), .step(step), .dir(dir), .busy(busy),
        .pos(pos), .at_open(at_open), .at_closed(at_closed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] lvl);
        light_level = lvl;
        light_valid = 1'b1;
        tick();
        light_valid = 1'b0;
    endtask

    task automatic push_run(input int from, input int to);
        if (from < to) for (int p = from + 1; p <= to; p++) q.push_back('{p, 1'b1});
        else for (int p = from - 1; p >= to; p--) q.push_back('{p, 1'b0});
    endtask

    task automatic drain();
        while (q.size() > 0) begin
            exp_t e;
            int n;
            logic seen;
            n = 0;
            seen = 1'b0;
            while (!seen && n < 2 * STEP_DIV) begin
                tick();
                n++;
                if (step) seen = 1'b1;
            end
            e = q.pop_front();
            check("step_gap", n, STEP_DIV);
            check("step_pos", int'(pos), e.pos);
            check("step_dir", int'(dir), int'(e.dir));
        end
    endtask

    task automatic quiet(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (step) cnt++;
        end
    endtask

    initial begin
        #3;
        check("rst_step", int'(step), 0);
        check("rst_pos", int'(pos), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_dir", int'(dir), 0);
        check("rst_at_open", int'(at_open), 1);
        check("rst_at_closed", int'(at_closed), 0);
        #24 rst_n = 1'b1;
        tick();

        send(8'd200);
        check("close_dir", int'(dir), 1);
        check("close_busy", int'(busy), 1);
        push_run(0, POS_MAX);
        drain();
        check("close_at_closed", int'(at_closed), 1);
        quiet(SETTLE_CYC, steps);
        check("close_busy_settle", int'(busy), 1);
        quiet(1, steps);
        check("close_busy_drop", int'(busy), 0);
        check("close_pos_end", int'(pos), POS_MAX);

        send(8'd20);
        check("open_dir", int'(dir), 0);
        check("open_busy", int'(busy), 1);
        push_run(POS_MAX, 0);
        drain();
        quiet(SETTLE_CYC + 1, steps);
        check("open_busy_drop", int'(busy), 0);
        check("open_at_open", int'(at_open), 1);
        quiet(3 * STEP_DIV, steps);
        check("open_no_extra_step", steps, 0);
        check("open_pos_end", int'(pos), 0);

        send(8'd100);
        check("band_busy", int'(busy), 0);
        quiet(2 * STEP_DIV, steps);
        check("band_steps", steps, 0);
        check("band_pos", int'(pos), 0);

        send(8'd200);
        push_run(0, 3);
        drain();
        send(8'd20);
        check("abort_busy", int'(busy), 1);
        check("abort_step", int'(step), 0);
        send(8'd200);
        check("settle_busy", int'(busy), 1);
        tick();
        check("settle_busy_last", int'(busy), 1);
        tick();
        check("abort_idle", int'(busy), 0);
        check("abort_dir_held", int'(dir), 1);
        quiet(2 * STEP_DIV, steps);
        check("abort_steps", steps, 0);
        check("abort_pos", int'(pos), 3);

        send(8'd20);
        check("reopen_dir", int'(dir), 0);
        push_run(3, 0);
        drain();
        quiet(SETTLE_CYC + 1, steps);
        check("reopen_idle", int'(busy), 0);
        check("reopen_at_open", int'(at_open), 1);

        thr_open = 8'd150;
        thr_close = 8'd50;
        send(8'd200);
        check("cfg_hi_busy", int'(busy), 0);
        send(8'd20);
        check("cfg_lo_busy", int'(busy), 0);
        quiet(2 * STEP_DIV, steps);
        check("cfg_steps", steps, 0);
        check("cfg_pos", int'(pos), 0);
        thr_open = 8'd50;
        thr_close = 8'd150;

        send(8'd200);
        push_run(0, 5);
        drain();
        #2 rst_n = 1'b0;
        #1;
        check("arst_step", int'(step), 0);
        check("arst_pos", int'(pos), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_dir", int'(dir), 0);
        check("arst_at_open", int'(at_open), 1);
        check("arst_at_closed", int'(at_closed), 0);
        #2 rst_n = 1'b1;
        quiet(2 * STEP_DIV, steps);
        check("arst_after_steps", steps, 0);
        check("arst_after_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
